// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception/interrupt controller owning CP0 Status/Cause/EPC/BadVAddr/Count/Compare.
// Define EXC_COMMIT_TIMER_EN to build the Count/Compare timer; without it Count/Compare read 0 and TI is 0.
module exc_commit_ctrl #(
    parameter int          INT_NUM    = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INT_NUM-1:0] ext_int,
    input  logic               commit_valid,
    input  logic [5:0]         commit_ex,
    input  logic [31:0]        commit_pc,
    input  logic               commit_bd,
    input  logic               commit_load,
    input  logic [31:0]        commit_addr,
    input  logic               commit_eret,
    input  logic               mtc0_wen,
    input  logic [4:0]         mtc0_addr,
    input  logic [31:0]        mtc0_wdata,
    input  logic [4:0]         mfc0_addr,
    output logic [31:0]        mfc0_rdata,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic               status_exl,
    output logic [31:0]        epc
);
    localparam int IPW = INT_NUM + 2;

    typedef enum logic {RUN, HANDLER} state_t;
    state_t state_q, state_d;

    logic [IPW-1:0]     im_q;
    logic               ie_q;
    logic [1:0]         ip_sw_q;
    logic [INT_NUM-1:0] ip_hw_q;
    logic [4:0]         exccode_q;
    logic               bd_q;
    logic [31:0]        epc_q, badvaddr_q;
    logic               flush_q;
    logic [31:0]        flush_pc_q;

    logic               ti;
    logic [31:0]        count_val, compare_val;

    logic [INT_NUM-1:0] ip_hw_eff;
    logic [IPW-1:0]     ip;
    logic               exl, int_req, int_take, ex_take, take, eret_acc, wr;
    logic [4:0]         code_d;

    assign exl = (state_q == HANDLER);

    // TI shares the top hardware IP line
    always_comb begin
        ip_hw_eff = ip_hw_q;
        ip_hw_eff[INT_NUM-1] = ip_hw_q[INT_NUM-1] | ti;
        ip = {ip_hw_eff, ip_sw_q};
    end

    assign int_req  = ie_q & ~exl & (|(ip & im_q));
    assign int_take = commit_valid & int_req;
    assign ex_take  = commit_valid & (|commit_ex);
    assign take     = int_take | ex_take;
    assign eret_acc = commit_valid & commit_eret & ~take;
    assign wr       = commit_valid & mtc0_wen & ~take;

    always_comb begin
        code_d = 5'd0;
        if (int_take)          code_d = 5'd0;
        else if (commit_ex[5]) code_d = 5'd4;
        else if (commit_ex[4]) code_d = 5'd10;
        else if (commit_ex[3]) code_d = 5'd12;
        else if (commit_ex[2]) code_d = 5'd9;
        else if (commit_ex[1]) code_d = 5'd8;
        else if (commit_ex[0]) code_d = commit_load ? 5'd4 : 5'd5;
    end

    always_comb begin
        state_d = state_q;
        if (take)
            state_d = HANDLER;
        else if (eret_acc)
            state_d = RUN;
        else if (wr && mtc0_addr == 5'd12)
            state_d = mtc0_wdata[1] ? HANDLER : RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q       <= '0;
            ie_q       <= 1'b0;
            ip_sw_q    <= 2'b00;
            ip_hw_q    <= '0;
            exccode_q  <= 5'd0;
            bd_q       <= 1'b0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            flush_q    <= 1'b0;
            flush_pc_q <= 32'd0;
        end else begin
            ip_hw_q <= ext_int;
            flush_q <= take | eret_acc;
            if (take) begin
                exccode_q  <= code_d;
                flush_pc_q <= EXC_VECTOR;
                if (!exl) begin
                    epc_q <= commit_bd ? commit_pc - 32'd4 : commit_pc;
                    bd_q  <= commit_bd;
                end
                if (!int_take && commit_ex[5])
                    badvaddr_q <= commit_pc;
                else if (!int_take && commit_ex[5:1] == 5'd0)
                    badvaddr_q <= commit_addr;
            end else begin
                if (eret_acc)
                    flush_pc_q <= epc_q;
                if (wr) begin
                    case (mtc0_addr)
                        5'd12: begin
                            im_q <= mtc0_wdata[8 +: IPW];
                            ie_q <= mtc0_wdata[0];
                        end
                        5'd13:   ip_sw_q <= mtc0_wdata[9:8];
                        5'd14:   epc_q   <= mtc0_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef EXC_COMMIT_TIMER_EN
    localparam logic [1:0] PRESC_MAX = 2'(COUNT_DIV - 1);
    logic [1:0]  presc_q;
    logic [31:0] count_q, compare_q;
    logic        ti_q;
    logic        count_wr, compare_wr;

    assign count_wr   = wr && mtc0_addr == 5'd9;
    assign compare_wr = wr && mtc0_addr == 5'd11;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= 2'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            if (count_wr) begin
                count_q <= mtc0_wdata;
                presc_q <= 2'd0;
            end else if (presc_q == PRESC_MAX) begin
                count_q <= count_q + 32'd1;
                presc_q <= 2'd0;
            end else begin
                presc_q <= presc_q + 2'd1;
            end
            if (compare_wr) begin
                compare_q <= mtc0_wdata;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign ti          = ti_q;
    assign count_val   = count_q;
    assign compare_val = compare_q;
`else
    assign ti          = 1'b0;
    assign count_val   = 32'd0;
    assign compare_val = 32'd0;
`endif

    logic [31:0] status_rd, cause_rd;
    always_comb begin
        status_rd = 32'h0040_0000;
        status_rd[8 +: IPW] = im_q;
        status_rd[1] = exl;
        status_rd[0] = ie_q;
        cause_rd = 32'd0;
        cause_rd[31] = bd_q;
        cause_rd[30] = ti;
        cause_rd[8 +: IPW] = ip;
        cause_rd[6:2] = exccode_q;
    end

    always_comb begin
        case (mfc0_addr)
            5'd8:    mfc0_rdata = badvaddr_q;
            5'd9:    mfc0_rdata = count_val;
            5'd11:   mfc0_rdata = compare_val;
            5'd12:   mfc0_rdata = status_rd;
            5'd13:   mfc0_rdata = cause_rd;
            5'd14:   mfc0_rdata = epc_q;
            default: mfc0_rdata = 32'd0;
        endcase
    end

    assign flush      = flush_q;
    assign flush_pc   = flush_pc_q;
    assign status_exl = exl;
    assign epc        = epc_q;
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Randomized bench for exc_commit_ctrl against an architectural CP0 model.
`timescale 1ns/100ps
module tb_exc_commit_ctrl;
    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int DIV = 2;
`ifdef EXC_COMMIT_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic [5:0] ext_int = '0;
    logic commit_valid = 0, commit_bd = 0, commit_load = 0, commit_eret = 0, mtc0_wen = 0;
    logic [5:0] commit_ex = '0;
    logic [31:0] commit_pc = '0, commit_addr = '0, mtc0_wdata = '0;
    logic [4:0] mtc0_addr = '0, mfc0_addr = '0;
    logic [31:0] mfc0_rdata, flush_pc, epc;
    logic flush, status_exl;

    exc_commit_ctrl #(.INT_NUM(6), .EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .ext_int(ext_int), .commit_valid(commit_valid),
        .commit_ex(commit_ex), .commit_pc(commit_pc), .commit_bd(commit_bd),
        .commit_load(commit_load), .commit_addr(commit_addr), .commit_eret(commit_eret),
        .mtc0_wen(mtc0_wen), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata), .flush(flush),
        .flush_pc(flush_pc), .status_exl(status_exl), .epc(epc));

    always #10 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // architectural state
    logic [7:0]  m_im;
    logic        m_ie, m_exl, m_bd, m_ti, m_flush;
    logic [1:0]  m_ip_sw;
    logic [5:0]  m_ip_hw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv, m_count, m_compare, m_flush_pc;
    int          m_ticks;

    task automatic model_reset();
        m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_flush = 0;
        m_ip_sw = 0; m_ip_hw = 0; m_code = 0; m_epc = 0; m_badv = 0;
        m_count = 0; m_compare = 0; m_flush_pc = 0; m_ticks = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_ip_hw[5] | m_ti, m_ip_hw[4:0], m_ip_sw};
    endfunction

    // advance the model by one clock using the inputs held across the edge
    task automatic model_step();
        logic irq, ti_int, ex_t, take, cnt_wr, cmp_wr;
        logic [31:0] old_epc, old_count, old_compare;
        logic old_ti;
        old_epc = m_epc; old_count = m_count; old_compare = m_compare; old_ti = m_ti;
        irq    = m_ie && !m_exl && ((m_ip() & m_im) != 0);
        ti_int = commit_valid && irq;
        ex_t   = commit_valid && (commit_ex != 0);
        take   = ti_int || ex_t;
        cnt_wr = 0; cmp_wr = 0;
        m_ip_hw = ext_int;
        m_flush = 0;
        if (take) begin
            if (ti_int)            m_code = 0;
            else if (commit_ex[5]) m_code = 4;
            else if (commit_ex[4]) m_code = 10;
            else if (commit_ex[3]) m_code = 12;
            else if (commit_ex[2]) m_code = 9;
            else if (commit_ex[1]) m_code = 8;
            else                   m_code = commit_load ? 5'd4 : 5'd5;
            if (!ti_int && commit_ex[5]) m_badv = commit_pc;
            else if (!ti_int && commit_ex == 6'b000001) m_badv = commit_addr;
            if (!m_exl) begin
                m_epc = commit_bd ? commit_pc - 4 : commit_pc;
                m_bd  = commit_bd;
            end
            m_exl = 1; m_flush = 1; m_flush_pc = VEC;
        end else begin
            if (commit_valid && commit_eret) begin
                m_exl = 0; m_flush = 1; m_flush_pc = old_epc;
            end
            if (commit_valid && mtc0_wen) begin
                case (mtc0_addr)
                    12: begin
                        m_im = mtc0_wdata[15:8]; m_ie = mtc0_wdata[0];
                        if (!commit_eret) m_exl = mtc0_wdata[1];
                    end
                    13: m_ip_sw = mtc0_wdata[9:8];
                    14: m_epc = mtc0_wdata;
                    9:  cnt_wr = TMR;
                    11: cmp_wr = TMR;
                    default: ;
                endcase
            end
        end
        if (TMR) begin
            if (cnt_wr) begin
                m_count = mtc0_wdata; m_ticks = 0;
            end else begin
                m_ticks++;
                if (m_ticks == DIV) begin m_ticks = 0; m_count = old_count + 1; end
            end
            if (cmp_wr) begin m_compare = mtc0_wdata; m_ti = 0; end
            else m_ti = old_ti || (old_count == old_compare);
        end
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        mfc0_addr = a; #1;
        chk(tag, mfc0_rdata, exp);
    endtask

    task automatic check_all();
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        if (m_flush) chk("flush_pc", flush_pc, m_flush_pc);
        chk("exl", {31'd0, status_exl}, {31'd0, m_exl});
        chk("epc", epc, m_epc);
        read_chk("status", 12, 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie));
        read_chk("cause", 13, {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00});
        read_chk("badvaddr", 8, m_badv);
        read_chk("count", 9, m_count);
        read_chk("compare", 11, m_compare);
        read_chk("epc_rd", 14, m_epc);
        read_chk("unmapped", 5'(3 + $urandom_range(0, 4)), 32'd0);
    endtask

    task automatic step();
        @(posedge clk); #1;
        model_step();
        check_all();
    endtask

    task automatic idle();
        commit_valid = 0; commit_ex = 0; commit_bd = 0; commit_load = 0;
        commit_eret = 0; mtc0_wen = 0; commit_pc = 0; commit_addr = 0;
    endtask

    task automatic commit(input logic [5:0] ex, input logic [31:0] pc, input logic bd, input logic er);
        commit_valid = 1; commit_ex = ex; commit_pc = pc; commit_bd = bd; commit_eret = er;
        commit_addr = $urandom; commit_load = 1'($urandom);
        step(); idle();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        commit_valid = 1; mtc0_wen = 1; mtc0_addr = a; mtc0_wdata = d;
        step(); idle();
    endtask

    initial begin
        idle();
        model_reset();
        #35 reset = 0;
        #1 check_all();
        step();

        // Sys exception then a reset while flush is high
        commit(6'b000010, 32'h8000_1000, 0, 0);
        chk("sys_flush_pc", flush_pc, VEC);
        chk("sys_epc", epc, 32'h8000_1000);
        reset = 1; #1;
        model_reset();
        chk("rst_flush", {31'd0, flush}, 32'd0);
        check_all();
        reset = 0; #1;
        step();

        // delay-slot overflow then eret
        commit(6'b001000, 32'h8000_2004, 1, 0);
        chk("ov_epc", epc, 32'h8000_2000);
        read_chk("ov_cause", 13, {1'b1, m_ti, 14'd0, m_ip(), 1'b0, 5'd12, 2'b00});
        step();
        commit(6'b000000, 32'h8000_2100, 0, 1);
        chk("eret_pc", flush_pc, 32'h8000_2000);
        chk("eret_exl", {31'd0, status_exl}, 32'd0);

        // interrupt beats a same-cycle breakpoint
        mtc0(12, 32'h0000_FF01);
        ext_int = 6'b000100;
        step();
        commit(6'b000100, 32'h8000_2200, 0, 0);
        mfc0_addr = 13; #1;
        chk("int_code", {27'd0, mfc0_rdata[6:2]}, 32'd0);
        chk("int_ip4", {31'd0, mfc0_rdata[12]}, 32'd1);
        ext_int = 0;
        mtc0(12, 32'h0);

        // exception while already in the handler
        commit(6'b000010, 32'h8000_1000, 0, 0);
        commit(6'b010000, 32'h8000_3000, 0, 0);
        chk("nest_epc", epc, 32'h8000_1000);
        chk("nest_pc", flush_pc, VEC);
        mtc0(12, 32'h0);

`ifdef EXC_COMMIT_TIMER_EN
        mtc0(11, 32'd5);
        mtc0(9, 32'd0);
        for (int i = 0; i < 40 && !m_ti; i++) step();
        mfc0_addr = 13; #1;
        chk("ti_set", {31'd0, mfc0_rdata[30]}, 32'd1);
        mtc0(11, 32'd5);
        mtc0(9, 32'd0);
        for (int i = 0; i < 40 && m_count != 32'd5; i++) step();
        mtc0(11, 32'd20);
        step();
        mfc0_addr = 13; #1;
        chk("ti_beat", {31'd0, mfc0_rdata[30]}, 32'd0);
        mtc0(9, 32'hFFFF_FFFE);
        repeat (6) step();
`endif

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
            commit_valid = ($urandom_range(0, 3) != 0);
            commit_pc    = {$urandom} & 32'hFFFF_FFFC;
            commit_addr  = $urandom;
            commit_bd    = 1'($urandom);
            commit_load  = 1'($urandom);
            commit_ex    = ($urandom_range(0, 9) == 0) ? 6'(1 << $urandom_range(0, 5)) |
                           (($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0) : 6'd0;
            commit_eret  = ($urandom_range(0, 9) == 0);
            mtc0_wen     = !commit_eret && ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 5))
                0: mtc0_addr = 12;
                1: mtc0_addr = 13;
                2: mtc0_addr = 14;
                3: mtc0_addr = 9;
                4: mtc0_addr = 11;
                default: mtc0_addr = 8;
            endcase
            mtc0_wdata = $urandom;
            if (mtc0_addr == 12 && $urandom_range(0, 1) == 0) mtc0_wdata[1] = 0;
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
